// File: rtl/ins_cache.sv
// ins_cache: direct-mapped read-only instruction cache, 16-byte lines refilled a word at a time
module ins_cache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] addr_in,
    output logic        hit,
    output logic [31:0] ins,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TW = 28 - INDEX_BITS;
    typedef enum logic {IDLE, FILL} state_t;
    state_t state, next_state;
    logic [LINES-1:0] valid;
    logic [TW-1:0] tags [LINES];
    logic [31:0] data [LINES][4];
    logic [1:0] cnt;
    logic [27:0] line_base;
    logic [INDEX_BITS-1:0] idx, fidx;
    logic start, wr, last;
    logic unused_lsb;
    assign unused_lsb = ^addr_in[1:0];
    assign idx = addr_in[3+INDEX_BITS:4];
    // line_base keeps addr[31:4], so its low bits are the fill index
    assign fidx = line_base[INDEX_BITS-1:0];
    assign hit = valid[idx] && tags[idx] == addr_in[31:4+INDEX_BITS];
    assign ins = data[idx][addr_in[3:2]];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = (state == IDLE) ? (start ? FILL : IDLE) : (last ? IDLE : FILL);
    end
    always_comb begin
        start = state == IDLE && rdy && !hit;
        wr = state == FILL && rdy && mem_done;
        last = wr && cnt == 2'd3;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            cnt <= '0;
            line_base <= '0;
            mem_req <= 1'b0;
            mem_addr <= '0;
        end else begin
            if (start) begin
                line_base <= addr_in[31:4];
                valid[idx] <= 1'b0;
                cnt <= '0;
                mem_req <= 1'b1;
                mem_addr <= {addr_in[31:4], 4'b0};
            end
            if (wr && !last) begin
                cnt <= cnt + 2'd1;
                mem_addr <= {line_base, cnt + 2'd1, 2'b00};
            end
            if (last) begin
                valid[fidx] <= 1'b1;
                mem_req <= 1'b0;
            end
        end
    end
    // tag and data arrays carry no reset; valid alone gates hits
    always_ff @(posedge clk) begin
        if (wr) data[fidx][cnt] <= mem_data;
        if (last) tags[fidx] <= line_base[27:INDEX_BITS];
    end
endmodule

// File: tb/tb_ins_cache.sv
// tb_ins_cache: directed and randomized checks of ins_cache against a line-level cache model
module tb_ins_cache;
    logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, mem_done = 1'b0;
    logic [31:0] addr_in = '0, mem_data = '0;
    logic hit, mem_req;
    logic [31:0] ins, mem_addr;
    always #5 clk = ~clk;

    ins_cache #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .addr_in(addr_in),
        .hit(hit), .ins(ins), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_done(mem_done), .mem_data(mem_data)
    );

    localparam logic [3:0] H = 4'd1, I = 4'd2, R = 4'd4, A = 4'd8;
    int checks = 0, errors = 0;
    bit auto_mode = 1'b0;
    bit lit_en = 1'b0;
    logic [3:0] lit_mask = '0;
    logic lit_hit = 1'b0, lit_req = 1'b0;
    logic [31:0] lit_ins = '0, lit_addr = '0;

    bit [15:0] mv;
    logic [23:0] mt [16];
    logic [31:0] md [16][4];
    bit filling;
    logic [31:0] fbase, maddr;
    int got, li;
    logic eh;

    function automatic logic [31:0] memfn(logic [31:0] a);
        return (a < 32'd16) ? 32'h11 * ((a >> 2) + 32'd1) : (a * 32'h01000193) ^ 32'hDEADBEEF;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // model: per-line valid/tag/words, plus the address of the line in flight
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req", 32'(mem_req), 32'd0);
            chk("rst_addr", mem_addr, 32'd0);
            chk("rst_hit", 32'(hit), 32'd0);
            mv = '0; filling = 1'b0; maddr = '0; got = 0; fbase = '0;
        end else begin
            li = int'(addr_in[7:4]);
            eh = mv[li] && mt[li] == addr_in[31:8];
            chk("hit", 32'(hit), 32'(eh));
            if (eh) chk("ins", ins, md[li][addr_in[3:2]]);
            chk("mem_req", 32'(mem_req), 32'(filling));
            chk("mem_addr", mem_addr, maddr);
            if (lit_en) begin
                if (lit_mask[0]) chk("lit_hit", 32'(hit), 32'(lit_hit));
                if (lit_mask[1]) chk("lit_ins", ins, lit_ins);
                if (lit_mask[2]) chk("lit_req", 32'(mem_req), 32'(lit_req));
                if (lit_mask[3]) chk("lit_addr", mem_addr, lit_addr);
            end
            if (rdy) begin
                if (!filling) begin
                    if (!eh) begin
                        filling = 1'b1; fbase = {addr_in[31:4], 4'b0}; got = 0;
                        mv[li] = 1'b0; maddr = fbase;
                    end
                end else if (mem_done) begin
                    md[fbase[7:4]][got] = memfn(fbase + 32'(4 * got));
                    got++;
                    if (got == 4) begin
                        mv[fbase[7:4]] = 1'b1; mt[fbase[7:4]] = fbase[31:8]; filling = 1'b0;
                    end else maddr = fbase + 32'(4 * got);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_mode) begin
            rdy = ($urandom % 8) != 0;
            if ($urandom % 4 == 0)
                addr_in = 32'((($urandom % 4) << 8) | (($urandom % 4) << 4) | (($urandom % 4) << 2));
            mem_done = mem_req && ($urandom % 3 == 0);
            mem_data = mem_done ? memfn(mem_addr) : $urandom;
        end else mem_done = 1'b0;
    endtask

    task automatic do_word();
        tick();
        mem_done = 1'b1;
        mem_data = memfn(mem_addr);
    endtask

    task automatic lit(logic [3:0] m, logic h, logic [31:0] i, logic r, logic [31:0] a);
        lit_mask = m; lit_hit = h; lit_ins = i; lit_req = r; lit_addr = a;
        lit_en = 1'b1;
        @(negedge clk);
        #1 lit_en = 1'b0;
    endtask

    initial begin
        tick(); tick();
        lit(H | R | A, 1'b0, 0, 1'b0, 0);
        tick(); rst = 1'b1; addr_in = 32'h0;
        lit(H | R, 1'b0, 0, 1'b0, 0);
        tick(); lit(R | A, 1'b0, 0, 1'b1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(); mem_done = 1'b1; mem_data = memfn(mem_addr);
            lit(R | A, 1'b0, 0, 1'b1, 32'(4 * k));
        end
        tick(); lit(H | I | R, 1'b1, 32'h11, 1'b0, 0);
        tick(); addr_in = 32'h8; lit(H | I, 1'b1, 32'h33, 1'b0, 0);
        // conflict eviction on index 0
        tick(); addr_in = 32'h100; lit(H, 1'b0, 0, 1'b0, 0);
        tick(); lit(R | A, 1'b0, 0, 1'b1, 32'h100);
        for (int k = 0; k < 4; k++) begin
            tick(); mem_done = 1'b1; mem_data = memfn(mem_addr);
            lit(R | A, 1'b0, 0, 1'b1, 32'h100 + 32'(4 * k));
        end
        tick(); addr_in = 32'h0; lit(H, 1'b0, 0, 1'b0, 0);
        repeat (4) do_word();
        // hit on another line during a fill
        tick(); addr_in = 32'h10;
        repeat (4) do_word();
        tick(); addr_in = 32'h200;
        repeat (2) do_word();
        tick(); addr_in = 32'h14; lit(H | I | R | A, 1'b1, memfn(32'h14), 1'b1, 32'h208);
        repeat (2) do_word();
        tick(); addr_in = 32'h200; lit(H | I | R, 1'b1, memfn(32'h200), 1'b0, 0);
        tick(); addr_in = 32'h20C; lit(H | I, 1'b1, memfn(32'h20C), 1'b0, 0);
        // redirect mid-fill never aborts the fill
        tick(); addr_in = 32'h40;
        repeat (2) do_word();
        tick(); addr_in = 32'h80;
        repeat (2) do_word();
        tick(); lit(H | R, 1'b0, 0, 1'b0, 0);
        tick(); lit(R | A, 1'b0, 0, 1'b1, 32'h80);
        tick(); addr_in = 32'h40; lit(H | I, 1'b1, memfn(32'h40), 1'b0, 0);
        repeat (4) do_word();
        // reset mid-fill
        tick(); addr_in = 32'h0;
        repeat (2) do_word();
        tick(); rst = 1'b0; lit(H | R | A, 1'b0, 0, 1'b0, 0);
        tick(); rst = 1'b1; lit(H | R, 1'b0, 0, 1'b0, 0);
        tick(); lit(R | A, 1'b0, 0, 1'b1, 32'h0);
        repeat (4) do_word();
        tick(); lit(H | I, 1'b1, 32'h11, 1'b0, 0);
        // rdy freeze with stray mem_done pulses
        tick(); addr_in = 32'h30;
        repeat (2) do_word();
        tick(); rdy = 1'b0;
        repeat (3) begin
            mem_done = 1'b1; mem_data = 32'hBAD0BAD0;
            lit(R | A, 1'b0, 0, 1'b1, 32'h38);
            tick();
        end
        rdy = 1'b1; mem_done = 1'b1; mem_data = memfn(mem_addr);
        lit(A, 1'b0, 0, 1'b0, 32'h38);
        do_word();
        tick(); addr_in = 32'h30; lit(H | I | R, 1'b1, memfn(32'h30), 1'b0, 0);
        tick(); addr_in = 32'h3C; lit(H | I, 1'b1, memfn(32'h3C), 1'b0, 0);
        tick(); auto_mode = 1'b1;
        repeat (3000) tick();
        auto_mode = 1'b0;
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
